seq_signed_multiplier: RTL and testbench

Sequential shift-add signed multiplier that sits directly downstream of the ALU's two's-complement negation stage. It takes two N-bit two's-complement operands and converts each to a magnitude, using the same negate rule: invert and add 1. It multiplies the magnitudes over N iterations, then negates the 2N-bit product when the operand signs differ. A start/busy/done handshake lets the ALU control FSM issue one multiply at a time.

---
 rtl/seq_signed_multiplier_if.sv | 11 +
 rtl/seq_signed_multiplier.sv | 74 +++++++
 tb/tb_seq_signed_multiplier.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_signed_multiplier_if.sv
// seq_signed_multiplier_if: start/busy/done handshake and operand/product bus for the multiplier
interface seq_signed_multiplier_if #(parameter int N = 8);
  logic start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2*N-1:0] Y;
  logic busy;
  logic done;
  modport master (output start, A, B, input Y, busy, done);
  modport slave (input start, A, B, output Y, busy, done);
endinterface

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: sequential shift-add two's-complement multiplier.
// Operands become magnitudes, are multiplied over N iterations, and the product is negated if the signs differ.
module seq_signed_multiplier #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  seq_signed_multiplier_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;
  state_t state_q, state_d;
  logic [N-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [2*N-1:0] acc_q, acc_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, done_q, done_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    y_d = y_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        // 8'h80 negates to itself and reads as unsigned 128, which is the correct magnitude
        mag_a_d = bus.A[N-1] ? ~bus.A + N'(1) : bus.A;
        mag_b_d = bus.B[N-1] ? ~bus.B + N'(1) : bus.B;
        neg_d = bus.A[N-1] ^ bus.B[N-1];
        acc_d = '0;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = mag_b_q[cnt_q] ? acc_q + ({{N{1'b0}}, mag_a_q} << cnt_q) : acc_q;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1)) ? SIGN : RUN;
      end
      SIGN: begin
        y_d = neg_q ? ~acc_q + (2*N)'(1) : acc_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      y_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      y_q <= y_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign bus.Y = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb_seq_signed_multiplier: directed and random checks against a plain signed-arithmetic reference.
module tb_seq_signed_multiplier;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  seq_signed_multiplier_if #(.N(N)) bus ();
  seq_signed_multiplier #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*N-1:0];
  endfunction
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = N'($urandom);
    bus.B = N'($urandom);
  endtask
  task automatic wait_done(input string tag, input logic [2*N-1:0] exp);
    int lat = 0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_y"}, 32'(bus.Y), 32'(exp));
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask
  task automatic mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    issue(a, b);
    wait_done(tag, ref_mul(a, b));
  endtask
  initial begin
    logic [N-1:0] ra, rb;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_y", 32'(bus.Y), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    mul("5x3", 8'd5, 8'd3);
    chk("5x3_ref", 32'(bus.Y), 32'h000F);
    @(negedge clk);
    chk("5x3_donefall", 32'(bus.done), 32'd0);
    chk("5x3_hold", 32'(bus.Y), 32'h000F);
    #2 rst = 1'b1;
    #1;
    chk("arst_y", 32'(bus.Y), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mul("m7x6", 8'hF9, 8'd6);
    chk("m7x6_k", 32'(bus.Y), 32'hFFD6);
    mul("m7xm6", 8'hF9, 8'hFA);
    chk("m7xm6_k", 32'(bus.Y), 32'h002A);
    mul("0xm1", 8'h00, 8'hFF);
    chk("0xm1_k", 32'(bus.Y), 32'h0000);
    mul("80x80", 8'h80, 8'h80);
    chk("80x80_k", 32'(bus.Y), 32'h4000);
    mul("80x7f", 8'h80, 8'h7F);
    chk("80x7f_k", 32'(bus.Y), 32'hC080);
    mul("7fx7f", 8'h7F, 8'h7F);
    chk("7fx7f_k", 32'(bus.Y), 32'h3F01);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd10;
    bus.B = 8'hFD;
    @(negedge clk);
    bus.A = 8'd3;
    bus.B = 8'd4;
    wait_done("held", 16'hFFE2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("held2", 16'h000C);
    mul("b2b1", 8'd2, 8'd3);
    issue(8'hFC, 8'd5);
    chk("b2b_donefall", 32'(bus.done), 32'd0);
    wait_done("b2b2", 16'hFFEC);
    @(negedge clk);
    issue(8'd7, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_y", 32'(bus.Y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done) seen++;
      end
      chk("abort_nodone", 32'(seen), 32'd0);
    end
    mul("9x9", 8'd9, 8'd9);
    chk("9x9_k", 32'(bus.Y), 32'h0051);
    repeat (40) begin
      ra = N'($urandom);
      rb = N'($urandom);
      mul("rand", ra, rb);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
